// File: rtl/dpr_burst_master.sv
// Burst read/write initiator driving one port of a true dual-port RAM (registered read data).
// Optional build macro: DPR_BURST_MASTER_RANGE_CHECK_EN rejects bursts that would run past RAM_SIZE-1.
module dpr_burst_master #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int RAM_SIZE  = 1 << ADDR_SIZE,
  parameter int LEN_SIZE  = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [LEN_SIZE-1:0]  cmd_len,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_din,
  input  logic [DATA_SIZE-1:0] ram_dout
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [LEN_SIZE-1:0]  cnt_q;
  logic                 inflight_q;
  logic                 done_q, err_q;

  logic [DATA_SIZE-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     fifo_cnt_q;

  logic                 accept, range_bad, wr_fire, issue, push, pop, done_d, err_d;
  logic [CNT_W:0]       occupancy;

`ifdef DPR_BURST_MASTER_RANGE_CHECK_EN
  localparam int SUM_W = ((ADDR_SIZE > LEN_SIZE) ? ADDR_SIZE : LEN_SIZE) + 1;
  logic [SUM_W-1:0] end_addr;
  // One extra bit so the last-word address cannot wrap before the compare.
  assign end_addr  = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign range_bad = 64'(end_addr) > 64'($unsigned(RAM_SIZE - 1));
`else
  logic unused_ram_size;
  assign unused_ram_size = (RAM_SIZE > 0);
  assign range_bad       = 1'b0;
`endif

  // Read slots already committed: buffered words plus the word on its way from the RAM.
  assign occupancy = {1'b0, fifo_cnt_q} + (CNT_W + 1)'(inflight_q);
  assign rd_valid  = (fifo_cnt_q != '0);
  assign rd_data   = fifo_mem[rd_ptr_q];
  assign pop       = rd_valid && rd_ready;
  assign push      = inflight_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wr_fire = 1'b0;
    issue   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (range_bad)      err_d   = 1'b1;
          else if (cmd_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          wr_fire = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (occupancy < DEPTH_C) begin
          issue = 1'b1;
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifo_cnt_q == '0 || (fifo_cnt_q == CNT_W'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign ram_en    = wr_fire || issue;
  assign ram_we    = wr_fire;
  assign ram_addr  = addr_q;
  assign ram_din   = wr_fire ? wr_data : '0;
  assign done      = done_q;
  assign err       = err_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= done_d;
      err_q      <= err_d;
      if (accept) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end else if (wr_fire || issue) begin
        addr_q <= addr_q + ADDR_SIZE'(1);
        cnt_q  <= cnt_q - LEN_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_dout;
  end

endmodule

// File: tb/tb_dpr_burst_master.sv
// Directed bench for dpr_burst_master with a behavioural single-port RAM model (1-cycle read).
// Inputs change on the falling edge; outputs are checked 1 ns later, away from the rising edge.
`timescale 1ns/1ps
module tb_dpr_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       busy, done, err;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  dpr_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: word at address a starts as ~a; read data registered one cycle.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    ram_dout = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_wr_ready"},  wr_ready,  0);
    check({tag, "_rd_valid"},  rd_valid,  0);
    check({tag, "_done"},      done,      0);
    check({tag, "_err"},       err,       0);
    check({tag, "_ram_en"},    ram_en,    0);
    check({tag, "_ram_we"},    ram_we,    0);
  endtask

  logic [7:0] a_dat   [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] b_dat   [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
  logic [7:0] c_dat   [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
  logic [7:0] fe_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic       pat     [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int         got;
    int         w;
    logic       seen_done;
    logic [7:0] exp_byte;

    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk); rst_n = 1;

    // 1a: write 0x10 len 3, wr_valid held
    @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10; cmd_len = 8'd3;
    #1 check("t1w_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cmd_valid = 0; wr_valid = 1; wr_data = a_dat[k];
      #1;
      check("t1w_wr_ready", wr_ready, 1);
      check("t1w_ram_en",   ram_en,   1);
      check("t1w_ram_we",   ram_we,   1);
      check("t1w_ram_addr", ram_addr, 8'h10 + 8'(k));
      check("t1w_ram_din",  ram_din,  a_dat[k]);
      check("t1w_done_lo",  done,     0);
    end
    @(negedge clk); wr_valid = 0;
    #1;
    check("t1w_done",   done,   1);
    check("t1w_busy",   busy,   0);
    check("t1w_ram_en", ram_en, 0);
    @(negedge clk); #1 check("t1w_done_pulse", done, 0);

    // 1b: read 0x10 len 3, rd_ready held
    @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10; cmd_len = 8'd3; rd_ready = 1;
    @(negedge clk); cmd_valid = 0;
    #1;
    check("t1r_ram_en",   ram_en,   1);
    check("t1r_ram_we",   ram_we,   0);
    check("t1r_ram_addr", ram_addr, 8'h10);
    check("t1r_rdv_t1",   rd_valid, 0);
    @(negedge clk);
    #1;
    check("t1r_ram_addr2", ram_addr, 8'h11);
    check("t1r_rdv_t2",    rd_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("t1r_rd_valid", rd_valid, 1);
      check("t1r_rd_data",  rd_data,  a_dat[k]);
      check("t1r_done_lo",  done,     0);
      if (k == 2) check("t1r_drain_no_en", ram_en, 0);
    end
    @(negedge clk);
    #1;
    check("t1r_done",     done,     1);
    check("t1r_rdv_done", rd_valid, 0);

    // 2: read 0x20 len 7 with rd_ready toggling
    @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20; cmd_len = 8'd7; rd_ready = 0;
    got = 0; seen_done = 0;
    for (int c = 0; c < 80 && !seen_done; c++) begin
      @(negedge clk); cmd_valid = 0; rd_ready = (c % 2 == 0);
      #1;
      if (rd_valid && rd_ready) begin
        exp_byte = ~(8'h20 + 8'(got));
        check("t2_rd_data", rd_data, exp_byte);
        got++;
      end
      if (done) seen_done = 1;
    end
    check("t2_count", got, 8);
    check("t2_done",  seen_done, 1);
    rd_ready = 0;

    // 3: write 0x40 len 3 with gapped wr_valid
    @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h40; cmd_len = 8'd3;
    w = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); cmd_valid = 0; wr_valid = pat[c]; wr_data = pat[c] ? b_dat[w] : 8'h00;
      #1;
      check("t3_ram_en", ram_en, pat[c]);
      check("t3_done_lo", done, 0);
      if (pat[c]) begin
        check("t3_ram_addr", ram_addr, 8'h40 + 8'(w));
        check("t3_ram_din",  ram_din,  b_dat[w]);
        w++;
      end
    end
    @(negedge clk); wr_valid = 0;
    #1 check("t3_done", done, 1);
    for (int k = 0; k < 4; k++) check("t3_mem", mem[8'h40 + 8'(k)], b_dat[k]);

    // 4: write at 0xFE len 3
    @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 8'hFE; cmd_len = 8'd3;
`ifndef DPR_BURST_MASTER_RANGE_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cmd_valid = 0; wr_valid = 1; wr_data = c_dat[k];
      #1;
      check("t4_ram_en",   ram_en,   1);
      check("t4_ram_addr", ram_addr, fe_addr[k]);
    end
    @(negedge clk); wr_valid = 0;
    #1;
    check("t4_done", done, 1);
    check("t4_err",  err,  0);
`else
    @(negedge clk); cmd_valid = 0; wr_valid = 1; wr_data = c_dat[0];
    #1;
    check("t4_err",       err,       1);
    check("t4_no_done",   done,      0);
    check("t4_cmd_ready", cmd_ready, 1);
    check("t4_ram_en",    ram_en,    0);
    check("t4_wr_ready",  wr_ready,  0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("t4_ram_en_idle", ram_en, 0);
      check("t4_err_pulse",   err,    0);
      check("t4_done_idle",   done,   0);
    end
    wr_valid = 0;
`endif

    // 5: read 0x20 len 7, reset after two handshakes
    @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h20; cmd_len = 8'd7; rd_ready = 1;
    #1 check("t5_cmd_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5_rd_valid0", rd_valid, 1);
    check("t5_rd_data0",  rd_data,  8'hDF);
    @(negedge clk);
    #1 check("t5_rd_data1", rd_data, 8'hDE);
    @(negedge clk); rst_n = 0;
    #1 check_reset_outputs("t5_rst");
    @(negedge clk); rst_n = 1;
    @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h00; cmd_len = 8'd0;
    #1 check("t5b_cmd_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 0;
    #1;
    check("t5b_ram_en",   ram_en,   1);
    check("t5b_ram_addr", ram_addr, 8'h00);
    @(negedge clk);
    #1 check("t5b_rdv_t2", rd_valid, 0);
    @(negedge clk);
    #1;
    check("t5b_rd_valid", rd_valid, 1);
`ifndef DPR_BURST_MASTER_RANGE_CHECK_EN
    check("t5b_rd_data", rd_data, 8'hC2);
`else
    check("t5b_rd_data", rd_data, 8'hFF);
`endif
    @(negedge clk);
    #1 check("t5b_done", done, 1);

    // 6: single-word read with cmd_valid held through the burst
    @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h30; cmd_len = 8'd0; rd_ready = 1;
    #1 check("t6_cmd_ready_t0", cmd_ready, 1);
    @(negedge clk);
    #1;
    check("t6_cmd_ready_t1", cmd_ready, 0);
    check("t6_busy_t1",      busy,      1);
    @(negedge clk);
    #1 check("t6_cmd_ready_t2", cmd_ready, 0);
    @(negedge clk);
    #1;
    check("t6_rd_valid",     rd_valid,  1);
    check("t6_rd_data",      rd_data,   8'hCF);
    check("t6_cmd_ready_t3", cmd_ready, 0);
    @(negedge clk);
    #1;
    check("t6_done",         done,      1);
    check("t6_cmd_ready_t4", cmd_ready, 1);
    @(negedge clk); cmd_valid = 0;
    #1;
    check("t6_second_busy",   busy,     1);
    check("t6_second_ram_en", ram_en,   1);
    check("t6_second_addr",   ram_addr, 8'h30);
    seen_done = 0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge clk);
      #1;
      if (done) seen_done = 1;
    end
    check("t6_second_done", seen_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpr_burst_master.md
Name: dpr_burst_master

Overview:
Initiator for one port of the true dual-port RAM (en/we/addr/din/dout port style). Accepts burst read/write commands over a valid/ready command channel, streams write data in and read data out with valid/ready flow control, and drives the RAM port cycle by cycle. Two instances, one per RAM port, give independent masters on ports A and B.

Parameters:
ADDR_SIZE, 8, RAM address width; matches the RAM's ADDR_SIZE.
DATA_SIZE, 8, data word width; matches the RAM's DATA_SIZE.
RAM_SIZE, 1 << ADDR_SIZE, number of valid RAM words; used only for the range check.
LEN_SIZE, 8, burst length field width; a burst is cmd_len+1 words.
OUT_DEPTH, 4, read-data output FIFO depth (power of 2, at least 4 for full rate).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when valid && ready.
cmd_write  in  1  1 = write burst, 0 = read burst.
cmd_addr  in  ADDR_SIZE  burst start address.
cmd_len  in  LEN_SIZE  word count minus 1.
wr_data  in  DATA_SIZE  write word.
wr_valid  in  1  write word valid.
wr_ready  out  1  write word accepted.
rd_data  out  DATA_SIZE  read word.
rd_valid  out  1  read word valid.
rd_ready  in  1  downstream accepts read word.
busy  out  1  burst in progress.
done  out  1  one-cycle pulse at burst completion.
err  out  1  one-cycle pulse on a rejected command; tied 0 without the optional feature.
ram_en  out  1  RAM port enable.
ram_we  out  1  RAM port write enable.
ram_addr  out  ADDR_SIZE  RAM port address.
ram_din  out  DATA_SIZE  RAM port write data.
ram_dout  in  DATA_SIZE  RAM port read data; registered, valid the cycle after ram_en && !ram_we.

Behaviour:
- Reset (asynchronous, rst_n low) forces:
  - state IDLE; cmd_ready=1.
  - wr_ready=0, rd_valid=0, busy=0, done=0, err=0.
  - ram_en=0, ram_we=0.
  - Address/count registers 0; FIFO and in-flight counter cleared.
- Reset mid-burst aborts immediately. RAM words already written stay written; buffered read data is discarded.
- States: IDLE, WRITE, READ, DRAIN.
- cmd_ready = (state==IDLE). busy = (state!=IDLE).
- Command accepted at cycle T: start address and length are latched, and at T+1 the state moves to WRITE (cmd_write=1) or READ.
- WRITE:
  - wr_ready=1.
  - In each cycle with wr_valid: ram_en=ram_we=1, ram_din=wr_data, ram_addr=current address. The address increments and the remaining count decrements.
  - Cycles without wr_valid issue no RAM access.
  - After the last word: IDLE next cycle, with done=1 in that cycle.
- READ:
  - Issue a read (ram_en=1, ram_we=0) when fifo_cnt + inflight < OUT_DEPTH, using registered counts.
  - inflight increments on issue and decrements when ram_dout is pushed into the FIFO (the cycle after issue).
  - After the last issue, go to DRAIN.
- FIFO behaviour:
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - Pop on rd_valid && rd_ready; push and pop may occur in the same cycle.
  - First rd_valid appears at T+3.
  - With rd_ready held 1, data streams one word per cycle.
- DRAIN: wait for inflight==0 and the FIFO to empty. Go to IDLE the cycle after the final read handshake, with done=1 in that cycle.
- Address arithmetic is modulo 2^ADDR_SIZE: 0xFF+1 = 0x00 at the defaults.
- cmd_len=0 gives a single-word burst.
- cmd_valid is ignored while busy.
- ram_we is never 1 while ram_en is 0.
- Read data order always equals address order.

Optional Feature:
- DPR_BURST_MASTER_RANGE_CHECK_EN defined:
  - A command with cmd_addr + cmd_len > RAM_SIZE-1 (computed without truncation) is accepted, but no RAM access occurs.
  - err pulses at T+1, with no done; cmd_ready stays 1.
- Not defined: no check is made, err is tied 0, and addresses wrap modulo 2^ADDR_SIZE.

Test Plan:
1. Write 0x10, len 3, wr_valid=1 with data A0,A1,A2,A3 -> ram_we at T+1..T+4 on addresses 10..13, done at T+5. Then read 0x10, len 3, rd_ready=1 -> rd_data A0..A3 on consecutive cycles starting T+3, done the cycle after the last handshake.
2. Read len 7 with rd_ready toggling 1,0,1,0 -> all 8 words delivered in order, no loss. fifo_cnt + inflight never exceeds OUT_DEPTH.
3. Write len 3 with wr_valid pattern 1,0,0,1,1,0,1 -> ram_en only in valid cycles, addresses contiguous, done after the 4th word.
4. Write at 0xFE, len 3 without the macro -> addresses FE, FF, 00, 01. With the macro -> err pulse, ram_en never asserted, no done, next command accepted.
5. Read len 7, rst_n asserted after 2 handshakes -> all outputs at reset values immediately. After release, a read of 0x00 len 0 returns the correct word with done.
6. Single-word read with cmd_valid held through the burst -> cmd_ready 0 while busy. A second command is accepted exactly in the done cycle.
